wfill_monitor: RTL
==================

# wfill_monitor

Write-domain status block for the asynchronous FIFO. It synchronizes the read-domain gray read pointer into wclk and feeds the synchronized value to the write-pointer/full logic. It decodes both gray pointers to binary and registers the FIFO fill level, a hysteretic almost-full flag and sticky error flags. It sits beside the write-pointer/full logic in the write clock domain and is the gray-to-binary decoder for the gray pointers that logic encodes.

## Interface
- ADDRSIZE, 5, memory address width; FIFO depth is 2^ADDRSIZE, pointers are ADDRSIZE+1 bits
- AFULL_SET, 28, level at or above which walmost_full asserts
- AFULL_CLR, 24, level at or below which walmost_full deasserts; AFULL_CLR < AFULL_SET <= 2^ADDRSIZE
- wclk  in  1  write clock
- wrst_n  in  1  reset, asynchronous, active-low
- rptr  in  ADDRSIZE+1  gray read pointer from the read domain, asynchronous to wclk
- wptr  in  ADDRSIZE+1  gray write pointer, wclk domain, registered
- winc  in  1  write request as presented to the write-pointer logic
- wfull  in  1  registered full flag from the write-pointer logic
- wclr_err  in  1  synchronous clear of the sticky error flags
- wq2_rptr  out  ADDRSIZE+1  rptr after two wclk flops, used by the full logic
- wlevel  out  ADDRSIZE+1  fill level, 0 to 2^ADDRSIZE
- walmost_full  out  1  hysteretic almost-full flag
- woverflow  out  1  sticky flag: write attempted while full
- wlevel_err  out  1  sticky flag: decoded level above 2^ADDRSIZE, indicating pointer corruption

## Operation
- Synchronizer: wq1_rptr <= rptr; wq2_rptr <= wq1_rptr. No logic between the two flops.
- Gray-to-binary decode, combinational, applied to both wptr and wq2_rptr: b[MSB] = g[MSB]; b[i] = b[i+1] ^ g[i].
- Next level: lvl_next = wbin_d - rbin_d, modulo 2^(ADDRSIZE+1) (ADDRSIZE+1-bit unsigned subtract, carry dropped). The result is correct across pointer wrap.
- wlevel <= lvl_next every cycle. The level is pessimistic: it over-reports by up to the reads not yet synchronized. It never under-reports.
- walmost_full, registered from lvl_next:
  - set when lvl_next >= AFULL_SET
  - clear when lvl_next <= AFULL_CLR
  - otherwise hold its value
- woverflow: sets the cycle after winc & wfull. Cleared by wclr_err. Set wins over clear in the same cycle.
- wlevel_err: sets when lvl_next > 2^ADDRSIZE. Same clear and priority rules as woverflow.
- Full: wptr equals wq2_rptr with the two MSBs inverted, so wlevel = 2^ADDRSIZE.
- Empty: wptr equals wq2_rptr, so wlevel = 0.
- The block never gates writes. It only observes them.

## Timing
- Reset: wq1_rptr, wq2_rptr, wlevel, walmost_full, woverflow and wlevel_err are all 0, asynchronously on wrst_n low. Reset is released synchronously to wclk.
- Reset mid-operation clears everything immediately, including the sticky flags. The first valid level appears one edge after release.
- wptr to wlevel/walmost_full: 1 wclk edge.
- rptr to wq2_rptr: 2 edges. rptr to wlevel: 3 edges.
- winc & wfull to woverflow: 1 edge.
- rptr changes at most one gray bit per read-clock step, so a metastable sample resolves to the old or new pointer. The level is then off by at most one entry, in the pessimistic direction.

## Structure
- Shared package fifo_pkg holds:
  - ADDRSIZE default
  - gray2bin and bin2gray functions, parameterized on width, shared with the write and read pointer logic
- Sub-module sync_r2w: two-flop, ADDRSIZE+1-bit synchronizer with async active-low reset. It is reused by the read side as sync_w2r.
- Remaining logic (decode, subtract, flags) stays flat in wfill_monitor.

## Test plan
- Reset: hold wrst_n low with rptr=0x3F, wptr=0x3F -> all outputs 0. After release and 3 edges, wq2_rptr=0x3F and wlevel=0.
- Fill: rptr=0. Step wptr through the gray codes for binary 1..5, ending at 0x07 -> wlevel follows one edge behind, ending at 5; walmost_full=0.
- Full and wrap: wptr=0x30 (binary 32), rptr=0 -> wlevel=32, walmost_full=1. Then wptr=0x3C (binary 40), rptr=0x36 (binary 36) -> wlevel=4 three edges after the rptr change; walmost_full=0.
- Hysteresis with defaults: level 27 -> flag 0; 28 -> 1; drop to 25 -> still 1; 24 -> 0; rise to 27 -> stays 0.
- Overflow: winc=1 with wfull=1 for one cycle -> woverflow=1 on the next edge, held until wclr_err. wclr_err coincident with a new winc & wfull -> woverflow stays 1.
- Level error: wptr=0x30, wq2_rptr settled at 0x3F (binary 42) -> lvl_next=54 > 32 -> wlevel_err=1 the next edge. wclr_err with sane pointers -> wlevel_err cleared the next edge.

Source files
------------

// File: rtl/fifo_pkg.sv
// Shared async-FIFO definitions: default address width and the gray/binary
// converters used by the write-side, read-side and monitor logic.
package fifo_pkg;

  localparam int ADDRSIZE   = 5;
  // Widest pointer the converters handle; callers zero-extend into this width
  // and pass their real pointer width so the conversion is width-agnostic.
  localparam int GRAY_MAX_W = 32;

  // Prefix-XOR from the MSB down: b[msb] = g[msb], b[i] = b[i+1] ^ g[i].
  function automatic logic [GRAY_MAX_W-1:0] gray2bin(input logic [GRAY_MAX_W-1:0] g,
                                                     input int width);
    logic [GRAY_MAX_W-1:0] b;
    logic                  acc;
    b   = '0;
    acc = 1'b0;
    for (int i = GRAY_MAX_W - 1; i >= 0; i--) begin
      if (i < width) begin
        acc  = acc ^ g[i];
        b[i] = acc;
      end
    end
    return b;
  endfunction

  function automatic logic [GRAY_MAX_W-1:0] bin2gray(input logic [GRAY_MAX_W-1:0] b,
                                                     input int width);
    logic [GRAY_MAX_W-1:0] r;
    r = '0;
    for (int i = 0; i < GRAY_MAX_W; i++) begin
      if (i < width) r[i] = b[i];
    end
    return r ^ (r >> 1);
  endfunction

endpackage

// File: rtl/sync_r2w.sv
// Two-flop pointer synchronizer. Plain flop-to-flop path so the second stage
// sees a resolved value; also instantiated on the read side as sync_w2r.
module sync_r2w #(
  parameter int WIDTH = 6
) (
  input  logic             clk_i,
  input  logic             rst_n_i,
  input  logic [WIDTH-1:0] d_i,
  output logic [WIDTH-1:0] q_o
);

  logic [WIDTH-1:0] q1_q;
  logic [WIDTH-1:0] q2_q;

  // Capture the foreign-domain pointer, then re-time it once more.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      q1_q <= '0;
      q2_q <= '0;
    end else begin
      q1_q <= d_i;
      q2_q <= q1_q;
    end
  end

  assign q_o = q2_q;

endmodule

// File: rtl/wfill_monitor.sv
// Write-domain FIFO status: synchronizes the read pointer, decodes both gray
// pointers, and registers fill level, hysteretic almost-full and sticky errors.
// The level is pessimistic: unsynchronized reads only make it read high.
module wfill_monitor #(
  parameter int ADDRSIZE  = fifo_pkg::ADDRSIZE,
  parameter int AFULL_SET = 28,
  parameter int AFULL_CLR = 24
) (
  input  logic              wclk,
  input  logic              wrst_n,
  input  logic [ADDRSIZE:0] rptr,
  input  logic [ADDRSIZE:0] wptr,
  input  logic              winc,
  input  logic              wfull,
  input  logic              wclr_err,
  output logic [ADDRSIZE:0] wq2_rptr,
  output logic [ADDRSIZE:0] wlevel,
  output logic              walmost_full,
  output logic              woverflow,
  output logic              wlevel_err
);

  import fifo_pkg::*;

  localparam int PW = ADDRSIZE + 1;
  localparam logic [PW-1:0] DEPTH_L = PW'(1) << ADDRSIZE;
  localparam logic [PW-1:0] SET_L   = PW'(AFULL_SET);
  localparam logic [PW-1:0] CLR_L   = PW'(AFULL_CLR);

  logic [PW-1:0] wq2_rptr_w;
  logic [PW-1:0] wbin_d;
  logic [PW-1:0] rbin_d;
  logic [PW-1:0] lvl_d;
  logic          afull_d;
  logic          ovf_d;
  logic          lerr_d;

  logic [PW-1:0] wlevel_q;
  logic          afull_q;
  logic          ovf_q;
  logic          lerr_q;

  sync_r2w #(
    .WIDTH (PW)
  ) u_sync_r2w (
    .clk_i   (wclk),
    .rst_n_i (wrst_n),
    .d_i     (rptr),
    .q_o     (wq2_rptr_w)
  );

  // Decode both pointers and derive the next level and flag values.
  always_comb begin
    wbin_d = PW'(gray2bin(GRAY_MAX_W'(wptr), PW));
    rbin_d = PW'(gray2bin(GRAY_MAX_W'(wq2_rptr_w), PW));
    // Modulo subtract: dropping the carry keeps the level right across wrap.
    lvl_d  = wbin_d - rbin_d;

    afull_d = afull_q;
    if (lvl_d >= SET_L) begin
      afull_d = 1'b1;
    end else if (lvl_d <= CLR_L) begin
      afull_d = 1'b0;
    end

    // Sticky flags: a new event outranks a clear in the same cycle.
    ovf_d  = (winc & wfull)     | (ovf_q  & ~wclr_err);
    lerr_d = (lvl_d > DEPTH_L)  | (lerr_q & ~wclr_err);
  end

  // Register level and flags; async reset also drops the sticky errors.
  always_ff @(posedge wclk or negedge wrst_n) begin
    if (!wrst_n) begin
      wlevel_q <= '0;
      afull_q  <= 1'b0;
      ovf_q    <= 1'b0;
      lerr_q   <= 1'b0;
    end else begin
      wlevel_q <= lvl_d;
      afull_q  <= afull_d;
      ovf_q    <= ovf_d;
      lerr_q   <= lerr_d;
    end
  end

  assign wq2_rptr     = wq2_rptr_w;
  assign wlevel       = wlevel_q;
  assign walmost_full = afull_q;
  assign woverflow    = ovf_q;
  assign wlevel_err   = lerr_q;

endmodule
